// File: rtl/inst_fetch_pkg.sv
// Shared constants and types for the instruction-fetch slice: bus widths,
// reset PC, instruction alignment and the fetch-mode debug encoding.
package inst_fetch_pkg;

    localparam int ADDR_BUS    = 32;
    localparam int DATA_BUS    = 32;
    localparam int MEM_SEL_BUS = 4;

    localparam logic [31:0] INIT_PC         = 32'h0000_0000;
    localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP         = 32'd4;

    // What the fetch stage is doing this cycle, exported for debug/checkers.
    typedef enum logic [1:0] {
        FETCH_NORMAL   = 2'd0,
        FETCH_STALL    = 2'd1,
        FETCH_REDIRECT = 2'd2,
        FETCH_RESET    = 2'd3
    } fetch_mode_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Request/response bus between the fetch stage (master) and the synchronous
// instruction ROM (slave).
interface inst_fetch_if
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_BUS,
    parameter int DATA_W = DATA_BUS
);
    // Handshake: rom_en=1 is a read request for rom_addr in that cycle; the
    // word appears on rom_read_data exactly one cycle later, with no
    // backpressure. When rom_en=0 the ROM drives zero the following cycle.
    logic                   rom_en;
    logic [MEM_SEL_BUS-1:0] rom_write_en;
    logic [ADDR_W-1:0]      rom_addr;
    logic [DATA_W-1:0]      rom_write_data;
    logic [DATA_W-1:0]      rom_read_data;

    modport master (
        output rom_en,
        output rom_write_en,
        output rom_addr,
        output rom_write_data,
        input  rom_read_data
    );

    modport slave (
        input  rom_en,
        input  rom_write_en,
        input  rom_addr,
        input  rom_write_data,
        output rom_read_data
    );
endinterface

// File: rtl/inst_hold_buf.sv
// Stall buffer for the fetched word: captures the ROM output on the first
// stall cycle and muxes it onto if_inst until the stall is released.
module inst_hold_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_cycle,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rom_read_data,
    output logic [DATA_W-1:0] buf_inst,
    output logic              hold_valid
);
    logic [DATA_W-1:0] hold_inst;

    // The ROM zeroes its output once rom_en drops, so the word must be caught
    // on the first stall cycle; later stall cycles keep the captured copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_inst  <= '0;
        end else if (hold_cycle) begin
            if (!hold_valid && rsp_valid) begin
                hold_inst  <= rom_read_data;
                hold_valid <= 1'b1;
            end
        end else begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_inst = hold_valid ? hold_inst : rom_read_data;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: issues PCs to the synchronous ROM, tags the
// returned words and handles stall, branch and flush redirects.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_BUS,
    parameter int                DATA_W   = DATA_BUS,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(INIT_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_pc,
    inst_fetch_if.master      rom,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_inst,
    output fetch_mode_e       dbg_mode,
    output logic              dbg_hold_valid
);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(~INST_ALIGN_MASK);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic              rsp_valid;

    logic              redirect;
    logic              hold_cycle;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] issue_addr;
    logic [DATA_W-1:0] buf_inst;

    // Flush beats stall and branch; a branch under stall is dropped because
    // decode has not consumed the branch instruction yet.
    assign redirect   = flush | (branch_en & ~stall);
    assign hold_cycle = stall & ~flush;
    assign tgt        = (flush ? flush_pc : branch_pc) & ALIGN_MASK;
    assign issue_addr = redirect ? tgt : pc;

    assign rom.rom_en         = rst_n & ~hold_cycle;
    assign rom.rom_addr       = issue_addr;
    assign rom.rom_write_en   = '0;
    assign rom.rom_write_data = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            rsp_pc    <= '0;
            rsp_valid <= 1'b0;
        end else if (!hold_cycle) begin
            pc        <= issue_addr + STEP;
            rsp_pc    <= issue_addr;
            rsp_valid <= 1'b1;
        end
    end

    inst_hold_buf #(
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold_cycle    (hold_cycle),
        .rsp_valid     (rsp_valid),
        .rom_read_data (rom.rom_read_data),
        .buf_inst      (buf_inst),
        .hold_valid    (dbg_hold_valid)
    );

    // The ROM output is not cleared by reset, so gate it while rst_n is low.
    assign if_valid = rsp_valid & ~redirect;
    assign if_pc    = rsp_pc;
    assign if_inst  = rst_n ? buf_inst : '0;

    always_comb begin
        dbg_mode = FETCH_NORMAL;
        if (!rst_n)         dbg_mode = FETCH_RESET;
        else if (redirect)  dbg_mode = FETCH_REDIRECT;
        else if (stall)     dbg_mode = FETCH_STALL;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: synchronous ROM model, cycle driver, and a
// scoreboard of fetched PCs checked against the decode-side outputs.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_en;
  logic [31:0] flush_pc, branch_pc;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  fetch_mode_e dbg_mode;
  logic        dbg_hold_valid;

  inst_fetch_if #(.ADDR_W(32), .DATA_W(32)) rom_bus ();

  inst_fetch #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .branch_en      (branch_en),
    .branch_pc      (branch_pc),
    .rom            (rom_bus),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .dbg_mode       (dbg_mode),
    .dbg_hold_valid (dbg_hold_valid)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model ----------------
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  always @(posedge clk) begin
    rom_bus.rom_read_data <= rom_bus.rom_en ? rom_word(rom_bus.rom_addr) : 32'h0;
  end

  // ---------------- scoreboard ----------------
  // Each entry is {issue cycle, fetch address}; an entry is the one decode
  // should see once the cycle it was issued in has passed.
  logic [63:0] exp_q[$];
  logic [31:0] model_next;
  logic        exp_en;
  logic [31:0] exp_addr;
  logic        cur_stall, cur_redirect;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic s, input logic f, input logic [31:0] fpc,
                       input logic b, input logic [31:0] bpc);
    logic        redir;
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    stall     = s;
    flush     = f;
    flush_pc  = fpc;
    branch_en = b;
    branch_pc = bpc;
    redir        = f | (b & ~s);
    cur_stall    = s;
    cur_redirect = redir;
    if (redir) begin
      tgt = (f ? fpc : bpc) & 32'hFFFF_FFFC;
      exp_q.delete();             // wrong-path word shown this cycle is squashed
      exp_q.push_back({32'(cyc), tgt});
      exp_en     = 1'b1;
      exp_addr   = tgt;
      model_next = tgt + 32'd4;
    end else if (s) begin
      exp_en = 1'b0;
    end else begin
      exp_q.push_back({32'(cyc), model_next});
      exp_en     = 1'b1;
      exp_addr   = model_next;
      model_next = model_next + 32'd4;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_rom_en",   32'(rom_bus.rom_en), 32'h0);
    chk("rst_async_if_valid", 32'(if_valid), 32'h0);
    chk("rst_async_if_pc",    if_pc, 32'h0);
    chk("rst_async_if_inst",  if_inst, 32'h0);
    exp_q.delete();
    model_next   = RST_PC;
    exp_en       = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    branch_en    = 1'b0;
    cur_stall    = 1'b0;
    cur_redirect = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_rom_en",   32'(rom_bus.rom_en), 32'h0);
      chk("rst_if_valid", 32'(if_valid), 32'h0);
      chk("rst_if_pc",    if_pc, 32'h0);
      chk("rst_if_inst",  if_inst, 32'h0);
    end else begin
      chk("rom_en", 32'(rom_bus.rom_en), 32'(exp_en));
      if (exp_en) chk("rom_addr", rom_bus.rom_addr, exp_addr);
      chk("rom_write_en",   32'(rom_bus.rom_write_en), 32'h0);
      chk("rom_write_data", rom_bus.rom_write_data, 32'h0);
      if (exp_q.size() > 0 && int'(exp_q[0][63:32]) < cyc) begin
        chk("if_valid", 32'(if_valid), 32'h1);
        chk("if_pc",    if_pc, exp_q[0][31:0]);
        chk("if_inst",  if_inst, rom_word(exp_q[0][31:0]));
        if (!cur_stall) void'(exp_q.pop_front());
      end else begin
        chk("if_valid_idle", 32'(if_valid), 32'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    branch_en    = 1'b0;
    flush_pc     = 32'h0;
    branch_pc    = 32'h0;
    cur_stall    = 1'b0;
    cur_redirect = 1'b0;
    exp_en       = 1'b0;
    exp_addr     = 32'h0;
    model_next   = RST_PC;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);

    // straight-line fetch from reset
    drive(0, 0, 0, 0, 0);                 // issue 1000
    drive(0, 0, 0, 0, 0);                 // issue 1004, show 1000
    // three-cycle stall holding 1004 / DEADBEEF
    repeat (3) drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);                 // release: consume 1004, issue 1008
    // unaligned branch target while 1008 is shown
    drive(0, 0, 0, 1, 32'h0000_2003);
    drive(0, 0, 0, 0, 0);
    // flush arriving in the middle of a stall with the buffer full
    repeat (2) drive(1, 0, 0, 0, 0);
    drive(1, 1, 32'h0000_0080, 0, 0);
    drive(0, 0, 0, 0, 0);
    // branch under stall is ignored
    drive(1, 0, 0, 1, 32'h0000_5000);
    drive(0, 0, 0, 0, 0);
    // PC wrap-around
    drive(0, 1, 32'hFFFF_FFFC, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // asynchronous reset mid-run, then restart
    async_reset();
    repeat (3) drive(0, 0, 0, 0, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      logic        s, f, b;
      logic [31:0] fpc, bpc;
      s   = ($urandom_range(0, 99) < 30);
      f   = ($urandom_range(0, 99) < 5);
      b   = ($urandom_range(0, 99) < 12);
      fpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 32'h0000_FFFF));
      bpc = $urandom;
      drive(s, f, fpc, b, bpc);
      if (i % 400 == 399) async_reset();
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
